pipe_out_arbiter: RTL and testbench

Round-robin block arbiter that shares one host pipe-out endpoint between NUM_SRC first-word-fall-through (FWFT) word sources, such as project output buffers. It sits in the ti_clk domain between the buffers and the okPipeOut / okWireOut endpoints. When a source holds a full block, the arbiter grants it and publishes the block length on the wire-out. It then streams a tagged header word followed by BLOCK_LEN payload words as the host strobes reads.

---
 rtl/pipe_out_arbiter_pkg.sv | 24 ++
 rtl/pipe_out_arbiter_rr_pick.sv | 26 ++
 rtl/pipe_out_arbiter.sv | 158 +++++++++++++++
 tb/tb_pipe_out_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_out_arbiter_pkg.sv
// Shared types and header layout for the pipe-out block arbiter.
package pipe_out_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } arb_state_e;

  localparam int WORD_W    = 16;
  localparam int HDR_TAG_W = 4;
  localparam int HDR_ID_W  = 4;
  localparam int HDR_SEQ_W = 8;

  localparam logic [HDR_TAG_W-1:0] HDR_TAG = 4'hA;

  function automatic logic [WORD_W-1:0] make_header(
    input logic [HDR_ID_W-1:0]  id,
    input logic [HDR_SEQ_W-1:0] seq
  );
    return {HDR_TAG, id, seq};
  endfunction

endpackage

// File: rtl/pipe_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after 'last', with wrap.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 4
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    int cand;
    cand  = 0;
    found = 1'b0;
    index = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(last) + k) % NUM_SRC;
      if (!found && eligible[cand]) begin
        found = 1'b1;
        index = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pipe_out_arbiter.sv
// Round-robin block arbiter sharing one host pipe-out endpoint between FWFT sources.
// Each granted block is a tagged header word followed by BLOCK_LEN payload words.
module pipe_out_arbiter
  import pipe_out_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int CNT_WIDTH = 11,
  parameter int BLOCK_LEN = 256
) (
  input  logic                          ti_clk,
  input  logic                          ti_rst_n,
  input  logic                          ti_enable,
  input  logic [NUM_SRC*CNT_WIDTH-1:0]  src_available,
  input  logic [NUM_SRC*WORD_W-1:0]     src_data,
  output logic [NUM_SRC-1:0]            src_pop,
  input  logic                          ti_out_data_en,
  output logic [WORD_W-1:0]             ti_out_data,
  output logic [WORD_W-1:0]             ti_out_available,
  output logic [HDR_ID_W-1:0]           grant_id,
  output logic                          busy,
  output logic                          underrun
);

  localparam logic [CNT_WIDTH-1:0] THRESH     = CNT_WIDTH'(BLOCK_LEN);
  localparam logic [WORD_W-1:0]    AVAIL_FULL = WORD_W'(BLOCK_LEN + 1);
  localparam logic [WORD_W-1:0]    WORDS_INIT = WORD_W'(BLOCK_LEN);
  localparam logic [HDR_ID_W-1:0]  LAST_INIT  = HDR_ID_W'(NUM_SRC - 1);

  arb_state_e             state, state_nxt;
  logic [WORD_W-1:0]      data_q, data_nxt;
  logic [WORD_W-1:0]      avail_q, avail_nxt;
  logic [WORD_W-1:0]      words_left, words_nxt;
  logic [HDR_SEQ_W-1:0]   seq, seq_nxt;
  logic [HDR_ID_W-1:0]    grant_q, grant_nxt;
  logic [HDR_ID_W-1:0]    last_grant, last_nxt;
  logic                   busy_q, busy_nxt;
  logic                   underrun_q, underrun_nxt;
  logic                   pop_any;
  logic [NUM_SRC-1:0]     eligible;
  logic                   pick_found;
  logic [HDR_ID_W-1:0]    pick_idx;
  logic [WORD_W-1:0]      head_word;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = ti_enable && (src_available[i*CNT_WIDTH +: CNT_WIDTH] >= THRESH);
    end
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (HDR_ID_W)
  ) u_rr_pick (
    .eligible (eligible),
    .last     (last_grant),
    .found    (pick_found),
    .index    (pick_idx)
  );

  always_comb begin
    head_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == HDR_ID_W'(i)) head_word = src_data[i*WORD_W +: WORD_W];
    end
  end

  // Next-state and register-input decode
  always_comb begin
    state_nxt    = state;
    data_nxt     = data_q;
    avail_nxt    = avail_q;
    words_nxt    = words_left;
    seq_nxt      = seq;
    grant_nxt    = grant_q;
    last_nxt     = last_grant;
    busy_nxt     = busy_q;
    underrun_nxt = underrun_q;
    pop_any      = 1'b0;
    unique case (state)
      IDLE: begin
        if (ti_out_data_en) underrun_nxt = 1'b1;
        if (pick_found) begin
          data_nxt  = make_header(pick_idx, seq);
          avail_nxt = AVAIL_FULL;
          busy_nxt  = 1'b1;
          seq_nxt   = seq + 1'b1;
          grant_nxt = pick_idx;
          last_nxt  = pick_idx;
          state_nxt = HEADER;
        end
      end
      HEADER: begin
        if (ti_out_data_en) begin
          pop_any   = 1'b1;
          data_nxt  = head_word;
          words_nxt = WORDS_INIT;
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (ti_out_data_en) begin
          if (words_left > 1) begin
            pop_any   = 1'b1;
            data_nxt  = head_word;
            words_nxt = words_left - 1'b1;
          end else begin
            // Host just took the final word already sitting in the register.
            data_nxt  = '0;
            avail_nxt = '0;
            busy_nxt  = 1'b0;
            words_nxt = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    src_pop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == HDR_ID_W'(i)) src_pop[i] = pop_any;
    end
  end

  always_ff @(posedge ti_clk or negedge ti_rst_n) begin
    if (!ti_rst_n) begin
      state      <= IDLE;
      data_q     <= '0;
      avail_q    <= '0;
      words_left <= '0;
      seq        <= '0;
      grant_q    <= '0;
      last_grant <= LAST_INIT;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_q     <= data_nxt;
      avail_q    <= avail_nxt;
      words_left <= words_nxt;
      seq        <= seq_nxt;
      grant_q    <= grant_nxt;
      last_grant <= last_nxt;
      busy_q     <= busy_nxt;
      underrun_q <= underrun_nxt;
    end
  end

  assign ti_out_data      = data_q;
  assign ti_out_available = avail_q;
  assign grant_id         = grant_q;
  assign busy             = busy_q;
  assign underrun         = underrun_q;

endmodule

// File: tb/tb_pipe_out_arbiter.sv
// Directed + randomized bench for pipe_out_arbiter against a block-level reference model.
module tb_pipe_out_arbiter;

  localparam int NSRC = 4;
  localparam int BLEN = 256;

  logic              ti_clk = 1'b0;
  logic              ti_rst_n = 1'b1;
  logic              ti_enable = 1'b0;
  logic [NSRC*11-1:0] src_available;
  logic [NSRC*16-1:0] src_data;
  logic [NSRC-1:0]   src_pop;
  logic              ti_out_data_en = 1'b0;
  logic [15:0]       ti_out_data;
  logic [15:0]       ti_out_available;
  logic [3:0]        grant_id;
  logic              busy;
  logic              underrun;

  logic [10:0] avail_arr [NSRC] = '{11'd0, 11'd0, 11'd0, 11'd0};
  logic [11:0] pop_cnt   [NSRC] = '{12'd0, 12'd0, 12'd0, 12'd0};

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_last;
  int m_seq;
  int exp_cnt [NSRC];

  always #5 ti_clk = ~ti_clk;

  pipe_out_arbiter #(
    .NUM_SRC   (NSRC),
    .CNT_WIDTH (11),
    .BLOCK_LEN (BLEN)
  ) dut (
    .ti_clk           (ti_clk),
    .ti_rst_n         (ti_rst_n),
    .ti_enable        (ti_enable),
    .src_available    (src_available),
    .src_data         (src_data),
    .src_pop          (src_pop),
    .ti_out_data_en   (ti_out_data_en),
    .ti_out_data      (ti_out_data),
    .ti_out_available (ti_out_available),
    .grant_id         (grant_id),
    .busy             (busy),
    .underrun         (underrun)
  );

  assign src_available = {avail_arr[3], avail_arr[2], avail_arr[1], avail_arr[0]};

  // FWFT sources: head word is {source id, running word index}
  always_comb begin
    src_data = '0;
    for (int i = 0; i < NSRC; i++) src_data[i*16 +: 16] = {4'(i), pop_cnt[i]};
  end

  always @(posedge ti_clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (src_pop[i]) pop_cnt[i] <= pop_cnt[i] + 12'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    int c;
    for (int k = 1; k <= NSRC; k++) begin
      c = (m_last + k) % NSRC;
      if (ti_enable && avail_arr[c] >= 11'(BLEN)) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = NSRC - 1;
    m_seq  = 0;
  endtask

  task automatic do_reset();
    @(negedge ti_clk);
    ti_out_data_en = 1'b0;
    ti_rst_n = 1'b0;
    #1;
    check("rst_data",  32'(ti_out_data), 32'h0);
    check("rst_avail", 32'(ti_out_available), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_under", 32'(underrun), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_pop",   32'(src_pop), 32'h0);
    @(negedge ti_clk);
    ti_rst_n = 1'b1;
    #1;
    model_reset();
  endtask

  // Expects a grant on the next edge, then performs n_reads host reads.
  task automatic run_block(input int n_reads, input int drop_at, input bit gaps);
    int src;
    int start;
    logic [15:0] exp_word;
    logic [3:0]  exp_pop;
    src = model_pick();
    if (src < 0) src = 0;
    start = exp_cnt[src];
    @(negedge ti_clk); #1;
    check("grant_busy",  32'(busy), 32'h1);
    check("grant_avail", 32'(ti_out_available), 32'(BLEN + 1));
    check("grant_id",    32'(grant_id), 32'(src));
    check("header",      32'(ti_out_data), 32'({4'hA, 4'(src), 8'(m_seq)}));
    for (int r = 0; r < n_reads; r++) begin
      if (gaps && $urandom_range(15) == 0) begin
        ti_out_data_en = 1'b0;
        #1;
        check("gap_pop", 32'(src_pop), 32'h0);
        @(negedge ti_clk); #1;
      end
      ti_out_data_en = 1'b1;
      #1;
      exp_word = (r == 0) ? {4'hA, 4'(src), 8'(m_seq)} : {4'(src), 12'(start + r - 1)};
      exp_pop  = (r < BLEN) ? 4'(1 << src) : 4'h0;
      check("word", 32'(ti_out_data), 32'(exp_word));
      check("pop",  32'(src_pop), 32'(exp_pop));
      if (r == drop_at) ti_enable = 1'b0;
      @(negedge ti_clk); #1;
    end
    ti_out_data_en = 1'b0;
    if (n_reads == BLEN + 1) begin
      check("end_avail", 32'(ti_out_available), 32'h0);
      check("end_busy",  32'(busy), 32'h0);
      check("end_data",  32'(ti_out_data), 32'h0);
    end
    m_seq  = (m_seq + 1) % 256;
    m_last = src;
    exp_cnt[src] = exp_cnt[src] + ((n_reads > BLEN) ? BLEN : n_reads);
  endtask

  initial begin
    int j;
    for (int i = 0; i < NSRC; i++) exp_cnt[i] = 0;
    model_reset();

    // Single source, full block
    do_reset();
    ti_enable = 1'b1;
    avail_arr[0] = 11'd256;
    run_block(BLEN + 1, -1, 1'b1);
    avail_arr[0] = 11'd0;

    // Threshold: 255 never grants, 256 grants one edge later
    do_reset();
    ti_enable = 1'b1;
    avail_arr[2] = 11'd255;
    for (int c = 0; c < 3; c++) begin
      @(negedge ti_clk); #1;
      check("thr_busy",  32'(busy), 32'h0);
      check("thr_avail", 32'(ti_out_available), 32'h0);
    end
    avail_arr[2] = 11'd256;
    run_block(BLEN + 1, -1, 1'b1);
    avail_arr[2] = 11'd0;

    // Round-robin with every source full
    do_reset();
    ti_enable = 1'b1;
    for (int i = 0; i < NSRC; i++) avail_arr[i] = 11'd256;
    for (int b = 0; b < 5; b++) run_block(BLEN + 1, -1, 1'b1);

    // Enable dropped after 10 payload reads: block completes, no new grant
    run_block(BLEN + 1, 10, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge ti_clk); #1;
      check("drop_busy",  32'(busy), 32'h0);
      check("drop_avail", 32'(ti_out_available), 32'h0);
    end

    // Read while idle
    check("under_pre", 32'(underrun), 32'h0);
    ti_out_data_en = 1'b1;
    #1;
    check("under_pop", 32'(src_pop), 32'h0);
    @(negedge ti_clk); #1;
    ti_out_data_en = 1'b0;
    check("under_set",  32'(underrun), 32'h1);
    check("under_data", 32'(ti_out_data), 32'h0);

    // Random eligibility across enough grants to wrap seq
    ti_enable = 1'b1;
    for (int b = 0; b < 257; b++) begin
      j = int'($urandom_range(NSRC - 1));
      for (int i = 0; i < NSRC; i++) avail_arr[i] = 11'($urandom_range(300, 200));
      avail_arr[j] = 11'($urandom_range(300, 256));
      run_block(BLEN + 1, -1, 1'b0);
    end
    check("under_sticky", 32'(underrun), 32'h1);

    // Reset in the middle of a payload
    for (int i = 0; i < NSRC; i++) avail_arr[i] = 11'd300;
    run_block(20, -1, 1'b0);
    ti_out_data_en = 1'b1;
    ti_rst_n = 1'b0;
    #1;
    check("mid_data",  32'(ti_out_data), 32'h0);
    check("mid_avail", 32'(ti_out_available), 32'h0);
    check("mid_pop",   32'(src_pop), 32'h0);
    check("mid_busy",  32'(busy), 32'h0);
    check("mid_under", 32'(underrun), 32'h0);
    check("mid_grant", 32'(grant_id), 32'h0);
    ti_out_data_en = 1'b0;
    @(negedge ti_clk);
    ti_rst_n = 1'b1;
    #1;
    model_reset();
    run_block(BLEN + 1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
